// File: rtl/matrix_seq_pkg.sv
// Shared definitions for the matrix multiply loop sequencer: FSM state
// encoding and default index width.
package matrix_seq_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/loop_counter.sv
// W-bit loop index with clear and increment; last flags idx == limit-1,
// computed modulo 2^W so a zero limit behaves as 2^W.
module loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] idx_o,
  output logic         last_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] idx_q;

  // Index register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= {W{1'b0}};
    end else if (clr_i) begin
      idx_q <= {W{1'b0}};
    end else if (inc_i) begin
      idx_q <= idx_q + ONE;
    end else begin
      idx_q <= idx_q;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == (limit_i - ONE));

endmodule

// File: rtl/matrix_loop_seq.sv
// Loop sequencer for an N x M x P matrix multiply (ROW, COL, CURR nests).
// Define MATRIX_LOOP_SEQ_ZERO_CHK_EN to reject zero dimensions with an err pulse.
module matrix_loop_seq
  import matrix_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] n_dim,
  input  logic [W-1:0] m_dim,
  input  logic [W-1:0] p_dim,
  input  logic         mem_ready,
  output logic [W-1:0] row_out,
  output logic [W-1:0] col_out,
  output logic [W-1:0] curr_out,
  output logic         acc_clr,
  output logic         mac_en,
  output logic         sum_wr,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_e       state_q;
  logic [W-1:0] n_q, m_q, p_q;
  logic         row_clr, row_inc, row_last;
  logic         col_clr, col_inc, col_last;
  logic         curr_clr, curr_inc, curr_last;
  logic         dim_zero;
  logic         accept;

`ifdef MATRIX_LOOP_SEQ_ZERO_CHK_EN
  assign dim_zero = (n_dim == {W{1'b0}}) || (m_dim == {W{1'b0}}) || (p_dim == {W{1'b0}});
`else
  assign dim_zero = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && start && !dim_zero;
  assign busy   = (state_q != ST_IDLE);

  // Strobes and counter controls decoded from state (and mem_ready in MAC).
  always_comb begin
    acc_clr  = 1'b0;
    mac_en   = 1'b0;
    sum_wr   = 1'b0;
    done     = 1'b0;
    row_clr  = 1'b0;
    row_inc  = 1'b0;
    col_clr  = 1'b0;
    col_inc  = 1'b0;
    curr_clr = 1'b0;
    curr_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          row_clr  = 1'b1;
          col_clr  = 1'b1;
          curr_clr = 1'b1;
        end else begin
          row_clr  = 1'b0;
        end
      end
      ST_CLR: begin
        acc_clr  = 1'b1;
        curr_clr = 1'b1;
      end
      ST_MAC: begin
        if (mem_ready) begin
          mac_en   = 1'b1;
          curr_inc = !curr_last;
        end else begin
          mac_en   = 1'b0;
        end
      end
      ST_STORE: begin
        sum_wr = 1'b1;
        // curr is zeroed only when another element follows, so the final
        // indices survive into DONE and IDLE.
        if (!col_last) begin
          col_inc  = 1'b1;
          curr_clr = 1'b1;
        end else begin
          col_clr = 1'b1;
          if (!row_last) begin
            row_inc  = 1'b1;
            curr_clr = 1'b1;
          end else begin
            row_inc  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // Sequencer FSM and dimension capture on start accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= {W{1'b0}};
      m_q     <= {W{1'b0}};
      p_q     <= {W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_CLR;
            n_q     <= n_dim;
            m_q     <= m_dim;
            p_q     <= p_dim;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLR:   state_q <= ST_MAC;
        ST_MAC: begin
          if (mem_ready && curr_last) begin
            state_q <= ST_STORE;
          end else begin
            state_q <= ST_MAC;
          end
        end
        ST_STORE: begin
          if (col_last && row_last) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_CLR;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MATRIX_LOOP_SEQ_ZERO_CHK_EN
  logic err_q;

  // A rejected start leaves the FSM in IDLE and raises err for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && start && dim_zero;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  loop_counter #(.W(W)) u_row (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (row_clr),
    .inc_i  (row_inc),
    .limit_i(n_q),
    .idx_o  (row_out),
    .last_o (row_last)
  );

  loop_counter #(.W(W)) u_col (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (col_clr),
    .inc_i  (col_inc),
    .limit_i(p_q),
    .idx_o  (col_out),
    .last_o (col_last)
  );

  loop_counter #(.W(W)) u_curr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (curr_clr),
    .inc_i  (curr_inc),
    .limit_i(m_q),
    .idx_o  (curr_out),
    .last_o (curr_last)
  );

endmodule

// File: tb/tb_matrix_loop_seq.sv
// Scoreboard bench for matrix_loop_seq: expected strobe events are queued in
// row-major order when a sweep starts and popped as the DUT emits strobes.
module tb_matrix_loop_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mem_ready = 1'b1;
  logic [W-1:0] n_dim = 8'd0, m_dim = 8'd0, p_dim = 8'd0;
  logic [W-1:0] row_out, col_out, curr_out;
  logic         acc_clr, mac_en, sum_wr, busy, done, err;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] k;
  } ev_t;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  matrix_loop_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .n_dim(n_dim), .m_dim(m_dim), .p_dim(p_dim), .mem_ready(mem_ready),
    .row_out(row_out), .col_out(col_out), .curr_out(curr_out),
    .acc_clr(acc_clr), .mac_en(mac_en), .sum_wr(sum_wr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ev_t mk(input logic [2:0] kd, input int r, input int c, input int k);
    ev_t e;
    e.kind = kd;
    e.r = r[7:0];
    e.c = c[7:0];
    e.k = k[7:0];
    return e;
  endfunction

  // Monitor: every strobe cycle pops one expected event (0 clr,1 mac,2 wr,3 done,4 err).
  always @(negedge clk) begin : mon
    int   nstb;
    ev_t  obs;
    ev_t  exp_ev;
    nstb = int'(acc_clr) + int'(mac_en) + int'(sum_wr) + int'(done) + int'(err);
    if (nstb > 0) begin
      vectors++;
      obs.kind = acc_clr ? 3'd0 : (mac_en ? 3'd1 : (sum_wr ? 3'd2 : (done ? 3'd3 : 3'd4)));
      obs.r = row_out;
      obs.c = col_out;
      obs.k = curr_out;
      if (nstb > 1) begin
        miscompares++;
        $display("FAIL strobe_excl: %0d strobes high, required 1", nstb);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got kind %0d at (%0d,%0d,%0d), required none",
                 obs.kind, obs.r, obs.c, obs.k);
      end else begin
        exp_ev = sb.pop_front();
        if ((obs.kind == 3'd4) ? (obs.kind !== exp_ev.kind) : (obs !== exp_ev)) begin
          miscompares++;
          $display("FAIL event_seq: got kind %0d (%0d,%0d,%0d), required kind %0d (%0d,%0d,%0d)",
                   obs.kind, obs.r, obs.c, obs.k, exp_ev.kind, exp_ev.r, exp_ev.c, exp_ev.k);
        end
      end
    end
  end

  task automatic run_sweep(input int n, input int m, input int p,
                           input int stall_at, input int stall_len, input int stall_curr,
                           input int retrig_at, input bit release_rst,
                           output int done_cyc);
    int m_eff;
    m_eff = (m == 0) ? 256 : m;
    done_cyc = -1;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < p; c++) begin
        sb.push_back(mk(3'd0, r, c, 0));
        for (int k = 0; k < m_eff; k++) sb.push_back(mk(3'd1, r, c, k));
        sb.push_back(mk(3'd2, r, c, m_eff - 1));
      end
    end
    sb.push_back(mk(3'd3, n - 1, 0, m_eff - 1));
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    start = 1'b1;
    n_dim = n[7:0];
    m_dim = m[7:0];
    p_dim = p[7:0];
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      mem_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (k == retrig_at) begin
        start = 1'b1;
        n_dim = 8'd5;
        m_dim = 8'd4;
        p_dim = 8'd6;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_run: busy=%b in cycle 1, required 1", busy);
        end
      end
      if (mem_ready == 1'b0) begin
        vectors++;
        if (mac_en !== 1'b0 || curr_out !== stall_curr[7:0]) begin
          miscompares++;
          $display("FAIL stall_hold: mac_en=%b curr=%0d, required mac_en=0 curr=%0d",
                   mac_en, curr_out, stall_curr);
        end
      end
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    mem_ready = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_end: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({row_out, col_out, curr_out, acc_clr, mac_en, sum_wr, busy, done, err} !== {(3*W+6){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_state: row=%0d col=%0d curr=%0d strobes=%b%b%b%b%b%b, required all 0",
               row_out, col_out, curr_out, acc_clr, mac_en, sum_wr, busy, done, err);
    end
  endtask

  task automatic test_basic();
    int dc;
    run_sweep(2, 2, 2, 0, 0, 0, 0, 1'b1, dc);
    vectors++;
    if (dc !== 17) begin
      miscompares++;
      $display("FAIL basic_2x2x2_latency: done in cycle %0d, required 17", dc);
    end
  endtask

  task automatic test_shapes();
    int dc;
    run_sweep(3, 1, 2, 0, 0, 0, 0, 1'b0, dc);
    vectors++;
    if (dc !== 19) begin
      miscompares++;
      $display("FAIL shape_3x1x2_latency: done in cycle %0d, required 19", dc);
    end
    run_sweep(1, 1, 1, 0, 0, 0, 0, 1'b0, dc);
    vectors++;
    if (dc !== 4) begin
      miscompares++;
      $display("FAIL shape_1x1x1_latency: done in cycle %0d, required 4", dc);
    end
  endtask

  task automatic test_stall();
    int dc;
    run_sweep(1, 3, 1, 3, 2, 1, 0, 1'b0, dc);
    vectors++;
    if (dc !== 8) begin
      miscompares++;
      $display("FAIL stall_latency: done in cycle %0d, required 8", dc);
    end
  endtask

  task automatic test_restart_ignored();
    int dc;
    run_sweep(2, 2, 2, 0, 0, 0, 5, 1'b0, dc);
    vectors++;
    if (dc !== 17) begin
      miscompares++;
      $display("FAIL restart_ignored_latency: done in cycle %0d, required 17", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    run_sweep(1, 2, 1, 0, 0, 0, 0, 1'b0, dc);
    vectors++;
    if (dc !== 5) begin
      miscompares++;
      $display("FAIL b2b_first_latency: done in cycle %0d, required 5", dc);
    end
    run_sweep(2, 1, 1, 0, 0, 0, 0, 1'b0, dc);
    vectors++;
    if (dc !== 7) begin
      miscompares++;
      $display("FAIL b2b_second_latency: done in cycle %0d, required 7", dc);
    end
  endtask

  task automatic test_reset_midrun();
    int dc;
    sb.push_back(mk(3'd0, 0, 0, 0));
    sb.push_back(mk(3'd1, 0, 0, 0));
    @(negedge clk);
    start = 1'b1;
    n_dim = 8'd3;
    m_dim = 8'd3;
    p_dim = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({row_out, col_out, curr_out, acc_clr, mac_en, sum_wr, busy, done, err} !== {(3*W+6){1'b0}}) begin
      miscompares++;
      $display("FAIL midrun_reset_outputs: row=%0d col=%0d curr=%0d strobes=%b%b%b%b%b%b, required all 0",
               row_out, col_out, curr_out, acc_clr, mac_en, sum_wr, busy, done, err);
    end
    repeat (3) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL midrun_prefix: pending=%0d events before reset, required 0", sb.size());
      sb.delete();
    end
    run_sweep(3, 3, 3, 0, 0, 0, 0, 1'b1, dc);
    vectors++;
    if (dc !== 46) begin
      miscompares++;
      $display("FAIL after_reset_latency: done in cycle %0d, required 46", dc);
    end
  endtask

  task automatic test_zero_dim();
`ifdef MATRIX_LOOP_SEQ_ZERO_CHK_EN
    sb.push_back(mk(3'd4, 0, 0, 0));
    @(negedge clk);
    start = 1'b1;
    n_dim = 8'd1;
    m_dim = 8'd0;
    p_dim = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_err_pulse: err=%b busy=%b, required err=1 busy=0", err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_err_width: err=%b in cycle 2, required 0", err);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_no_run: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
      sb.delete();
    end
`else
    int dc;
    run_sweep(1, 0, 1, 0, 0, 0, 0, 1'b0, dc);
    vectors++;
    if (dc !== 259) begin
      miscompares++;
      $display("FAIL zero_wrap_latency: done in cycle %0d, required 259", dc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shapes();
    test_stall();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_zero_dim();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_loop_seq.md
MATRIX_LOOP_SEQ -- requirements
Module: matrix_loop_seq

Interface
REQ-001 Parameter: W, default 8, width of dimensions and loop indices.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to run one full N x M x P multiply sweep.
REQ-005 n_dim  input  W  row count N, sampled on start accept.
REQ-006 m_dim  input  W  inner (CURR) count M, sampled on start accept.
REQ-007 p_dim  input  W  column count P, sampled on start accept.
REQ-008 mem_ready  input  1  operand memory ready; low stalls the MAC step.
REQ-009 row_out  output  W  current ROW index.
REQ-010 col_out  output  W  current COL index.
REQ-011 curr_out  output  W  current CURR (inner) index.
REQ-012 acc_clr  output  1  clear SUM accumulator strobe.
REQ-013 mac_en  output  1  multiply-accumulate strobe for (row, curr, col).
REQ-014 sum_wr  output  1  write SUM to result element (row, col) strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  one-cycle zero-dimension error pulse (macro-dependent, REQ-036).

Function
REQ-018 FSM states SHALL be IDLE, CLR, MAC, STORE, DONE.
REQ-019 IDLE: start=1 at an edge latches n/m/p_dim, zeroes row/col/curr, and enters CLR.
REQ-020 start SHALL be ignored in every state other than IDLE; dimension inputs are not re-sampled mid-run.
REQ-021 CLR: acc_clr=1 for exactly one cycle, curr=0, next state MAC.
REQ-022 MAC with mem_ready=1: mac_en=1; if curr==m-1 go to STORE, else curr+1 and stay.
REQ-023 MAC with mem_ready=0: mac_en=0, indices and state held.
REQ-024 STORE: sum_wr=1 for one cycle; if col!=p-1: col+1 and go to CLR; else col=0 and, if row!=n-1, row+1 and go to CLR, else go to DONE.
REQ-025 DONE: done=1 for one cycle, next state IDLE; row/col/curr retain final values until next start.
REQ-026 acc_clr, mac_en, sum_wr, done SHALL be mutually exclusive and combinational from state and mem_ready.
REQ-027 Latency with mem_ready constantly 1: done is high in cycle N*P*(M+2)+1 after the start-accept edge.
REQ-028 Index comparisons SHALL use (dim-1) modulo 2^W; counters are W bits.
REQ-029 Element order SHALL be row-major: col fastest across elements, curr fastest within an element.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and drive row_out, col_out, curr_out to 0 and all strobes, busy, done, err to 0.
REQ-031 Reset asserted mid-run SHALL abort the sweep with no further strobes; no done pulse is issued.
REQ-032 After rst_n deassertion the block SHALL accept start on the first rising edge.

Configuration
REQ-033 Macro MATRIX_LOOP_SEQ_ZERO_CHK_EN selects zero-dimension handling.
REQ-034 With the macro defined: start accepted with any of n/m/p_dim==0 pulses err for one cycle, issues no acc_clr/mac_en/sum_wr/done, and returns to IDLE.
REQ-035 Without the macro: a zero dimension is treated as 2^W (wrap of dim-1 to all-ones), err is tied to 0.
REQ-036 err port SHALL exist in both builds.

Structure
REQ-037 Shared package matrix_seq_pkg SHALL hold the FSM state enumeration and the default W constant.
REQ-038 One sub-module loop_counter (W-bit index with clear, inc, and last = (idx==limit-1)) SHALL be instantiated three times for ROW, COL, CURR.

Verification
REQ-039 N=M=P=2, mem_ready=1: 4 sum_wr pulses at indices (0,0),(0,1),(1,0),(1,1); 8 mac_en; done in cycle 17.
REQ-040 N=1,M=3,P=1, mem_ready low for 2 cycles during curr=1: mac_en gaps of 2, curr holds at 1, done in cycle 8.
REQ-041 start pulsed again while busy with different dims: ignored; original sweep completes unchanged.
REQ-042 rst_n low during MAC of N=M=P=3 run: all outputs 0 immediately, no done; new start runs cleanly.
REQ-043 m_dim=0 with macro: err pulse one cycle after start, no other strobes; without macro: 256 mac_en per element.
